// File: rtl/address_op16_pkg.sv
// Shared types and default sizing for the address_op16 sweep scheduler.
package address_op16_pkg;

  localparam int unsigned DEF_GROUP_W = 8;
  localparam int unsigned DEF_SWEEP_W = 16;
  localparam int unsigned DEF_MAX_OUT = 4;

  typedef logic [DEF_GROUP_W-1:0] group_t;
  typedef logic [DEF_SWEEP_W-1:0] sweep_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SYNC,
    DRAIN,
    DONE
  } sched_state_t;

  // Bits needed to hold an outstanding count of 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating outstanding-request counter; a response with nothing outstanding
// is flagged as underflow and does not move the count.
module credit_counter
  import address_op16_pkg::*;
#(
  parameter int unsigned MAX_OUT = DEF_MAX_OUT,
  parameter int unsigned CNT_W   = cnt_width(MAX_OUT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_max_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_eff;

  always_comb begin
    underflow_o = dec_i && (count_q == '0);
    dec_eff     = dec_i && !underflow_o;
    count_d     = count_q;
    if (inc_i && !dec_eff) begin
      count_d = count_q + CNT_W'(1);
    end else if (!inc_i && dec_eff) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == CNT_W'(MAX_OUT));

endmodule

// File: rtl/address_op16_sched.sv
// Sweep scheduler: issues one request per 16-spin group, bounded by credits,
// with a full drain barrier between sweeps so sweep k+1 sees sweep k's writes.
module address_op16_sched
  import address_op16_pkg::*;
#(
  parameter int unsigned GROUP_W = DEF_GROUP_W,
  parameter int unsigned SWEEP_W = DEF_SWEEP_W,
  parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [GROUP_W-1:0] cfg_num_groups,
  input  logic [SWEEP_W-1:0] cfg_num_sweeps,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [GROUP_W-1:0] req_group,
  output logic [SWEEP_W-1:0] req_sweep,
  output logic               req_last,
  input  logic               rsp_valid,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               err_rsp
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUT);

  sched_state_t       state_q;
  logic [GROUP_W-1:0] group_q, num_groups_q;
  logic [SWEEP_W-1:0] sweep_q, num_sweeps_q;
  logic               busy_q, done_q, aborted_q, err_rsp_q;

  logic [CNT_W-1:0]   count;
  logic               at_max, underflow, xfer, no_credit_used;
  logic               last_group, last_sweep;

  credit_counter #(
    .MAX_OUT(MAX_OUT),
    .CNT_W  (CNT_W)
  ) u_credit (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .inc_i      (xfer),
    .dec_i      (rsp_valid),
    .count_o    (count),
    .at_max_o   (at_max),
    .underflow_o(underflow)
  );

  // Valid depends only on registered state and count, so it cannot drop
  // before its transfer: the count only falls while waiting.
  assign req_valid      = (state_q == ISSUE) && !at_max;
  assign xfer           = req_valid && req_ready;
  assign no_credit_used = (count == '0);
  assign last_group     = (group_q == num_groups_q - GROUP_W'(1));
  assign last_sweep     = (sweep_q == num_sweeps_q - SWEEP_W'(1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      group_q      <= '0;
      sweep_q      <= '0;
      num_groups_q <= '0;
      num_sweeps_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_rsp_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (underflow) begin
        err_rsp_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            num_groups_q <= cfg_num_groups;
            num_sweeps_q <= cfg_num_sweeps;
            group_q      <= '0;
            sweep_q      <= '0;
            aborted_q    <= 1'b0;
            err_rsp_q    <= underflow;
            busy_q       <= 1'b1;
            if ((cfg_num_groups == '0) || (cfg_num_sweeps == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (xfer) begin
            group_q <= group_q + GROUP_W'(1);
          end
          // A presented request must complete before abort takes effect.
          if (cfg_abort && (xfer || !req_valid)) begin
            state_q   <= DRAIN;
            aborted_q <= 1'b1;
          end else if (xfer && last_group) begin
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (cfg_abort) begin
            state_q   <= DRAIN;
            aborted_q <= 1'b1;
          end else if (no_credit_used) begin
            if (last_sweep) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              sweep_q <= sweep_q + SWEEP_W'(1);
              group_q <= '0;
              state_q <= ISSUE;
            end
          end
        end
        DRAIN: begin
          if (no_credit_used) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_group = group_q;
  assign req_sweep = sweep_q;
  assign req_last  = req_valid && last_group;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err_rsp   = err_rsp_q;

endmodule

// File: tb/tb_address_op16_sched.sv
// Scoreboard bench for address_op16_sched: expected requests are queued at
// start and matched against each observed transfer.
module tb_address_op16_sched;

  localparam int MAX_OUT = 4;

  typedef struct packed {
    logic [7:0]  g;
    logic [15:0] s;
    logic        last;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESET, cfg_start, cfg_abort, req_ready, rsp_valid;
  logic [7:0]  cfg_num_groups;
  logic [15:0] cfg_num_sweeps;
  logic        req_valid, req_last, busy, done, aborted, err_rsp;
  logic [7:0]  req_group;
  logic [15:0] req_sweep;

  int   n_checks = 0, n_pass = 0;
  int   cyc = 0, n_xfer = 0, n_done = 0, n_valid = 0, tb_out = 0;
  bit   auto_rsp = 1'b0;
  int   rsp_due[$];
  exp_t exp_q[$];
  int   base_x, base_d, base_v;

  address_op16_sched #(
    .GROUP_W(8),
    .SWEEP_W(16),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_num_groups(cfg_num_groups),
    .cfg_num_sweeps(cfg_num_sweeps),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_group     (req_group),
    .req_sweep     (req_sweep),
    .req_last      (req_last),
    .rsp_valid     (rsp_valid),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .err_rsp       (err_rsp)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock: note what will transfer at the edge, then sample 1 time unit after.
  task automatic step();
    logic xfer, rsp;
    exp_t got, e;
    xfer = req_valid && req_ready;
    rsp  = rsp_valid;
    got  = '{g: req_group, s: req_sweep, last: req_last};
    @(posedge ACLK);
    #1;
    cyc++;
    if (xfer) begin
      n_xfer++;
      check("req_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req_group", 32'(got.g), 32'(e.g));
        check("req_sweep", 32'(got.s), 32'(e.s));
        check("req_last", 32'(got.last), 32'(e.last));
        if (e.g == 8'd0 && e.s != 16'd0) check("sweep_barrier", 32'(tb_out), 32'd0);
      end
      tb_out++;
      check("credit_limit", 32'(tb_out <= MAX_OUT), 32'd1);
      if (auto_rsp) rsp_due.push_back(cyc + 1);
    end
    if (rsp && tb_out > 0) tb_out--;
    if (done) n_done++;
    if (req_valid) n_valid++;
    rsp_valid = 1'b0;
    if (auto_rsp && rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      void'(rsp_due.pop_front());
    end
  endtask

  task automatic run_start(input int g, input int s);
    cfg_num_groups = 8'(g);
    cfg_num_sweeps = 16'(s);
    cfg_start      = 1'b1;
    for (int sw = 0; sw < s && g > 0; sw++) begin
      for (int gi = 0; gi < g; gi++) begin
        exp_q.push_back('{g: 8'(gi), s: 16'(sw), last: (gi == g - 1)});
      end
    end
    step();
    cfg_start = 1'b0;
  endtask

  task automatic flush_rsps();
    auto_rsp = 1'b1;
    for (int i = 0; i < tb_out; i++) rsp_due.push_back(cyc);
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = n_done;
    for (int i = 0; i < budget && n_done == base; i++) step();
    check("done_seen", 32'(n_done > base), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    cfg_num_groups = '0; cfg_num_sweeps = '0;
    repeat (3) step();
    check("reset_outputs", 32'({req_valid, req_group, req_sweep, req_last, busy, done,
                                aborted, err_rsp}), 32'd0);
    ARESET = 1'b0;
    step();

    // Two sweeps of four groups, responses two cycles after each transfer.
    req_ready = 1'b1; auto_rsp = 1'b1; base_x = n_xfer; base_d = n_done;
    run_start(4, 2);
    wait_done(100);
    step(); step();
    check("t1_xfers", 32'(n_xfer - base_x), 32'd8);
    check("t1_pending", 32'(exp_q.size()), 32'd0);
    check("t1_done_once", 32'(n_done - base_d), 32'd1);
    check("t1_aborted", 32'(aborted), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_err_rsp", 32'(err_rsp), 32'd0);

    // Credit cap with responses withheld.
    auto_rsp = 1'b0; base_x = n_xfer;
    run_start(8, 1);
    repeat (8) step();
    check("t2_xfers_capped", 32'(n_xfer - base_x), 32'd4);
    check("t2_valid_low", 32'(req_valid), 32'd0);
    rsp_valid = 1'b1;
    step();
    check("t2_valid_after_rsp", 32'(req_valid), 32'd1);
    step();
    check("t2_fifth_xfer", 32'(n_xfer - base_x), 32'd5);
    flush_rsps();
    wait_done(200);
    step();
    check("t2_xfers", 32'(n_xfer - base_x), 32'd8);

    // Stalled request holds its fields; simultaneous transfer+rsp keeps count.
    auto_rsp = 1'b0; base_x = n_xfer;
    run_start(6, 1);
    for (int i = 0; i < 10 && n_xfer - base_x < 3; i++) step();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", 32'(req_valid), 32'd1);
      check("t3_hold_group", 32'(req_group), 32'd3);
      check("t3_hold_sweep", 32'(req_sweep), 32'd0);
    end
    req_ready = 1'b1; rsp_valid = 1'b1;
    step();
    check("t3_same_cycle_valid", 32'(req_valid), 32'd1);
    step();
    check("t3_full_valid_low", 32'(req_valid), 32'd0);
    check("t3_xfers", 32'(n_xfer - base_x), 32'd5);
    flush_rsps();
    wait_done(200);
    step();
    check("t3_pending", 32'(exp_q.size()), 32'd0);

    // Abort arriving with the second transfer.
    auto_rsp = 1'b0; base_x = n_xfer; base_d = n_done;
    run_start(6, 1);
    step();
    check("t4_group1_presented", 32'(req_group), 32'd1);
    cfg_abort = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_req", 32'(req_valid), 32'd0);
    end
    cfg_abort = 1'b0;
    check("t4_xfers", 32'(n_xfer - base_x), 32'd2);
    rsp_valid = 1'b1;
    step();
    check("t4_not_done_early", 32'(n_done - base_d), 32'd0);
    rsp_valid = 1'b1;
    step();
    wait_done(4);
    check("t4_aborted", 32'(aborted), 32'd1);
    step();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done_once", 32'(n_done - base_d), 32'd1);
    exp_q.delete();

    // Empty configurations, then a start while busy.
    base_d = n_done; base_v = n_valid;
    run_start(0, 3);
    step();
    check("t5_done_groups0", 32'(n_done - base_d), 32'd1);
    run_start(4, 0);
    step();
    check("t5_done_sweeps0", 32'(n_done - base_d), 32'd2);
    check("t5_no_valid", 32'(n_valid - base_v), 32'd0);
    check("t5_busy_idle", 32'(busy), 32'd0);
    req_ready = 1'b0; auto_rsp = 1'b1; base_x = n_xfer;
    run_start(2, 1);
    step();
    check("t5_busy", 32'(busy), 32'd1);
    cfg_num_groups = 8'd7; cfg_num_sweeps = 16'd5; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0; req_ready = 1'b1;
    wait_done(50);
    step();
    check("t5_ignored_start", 32'(n_xfer - base_x), 32'd2);
    check("t5_pending", 32'(exp_q.size()), 32'd0);

    // Reset mid-run, spurious response, then a clean restart.
    auto_rsp = 1'b0;
    run_start(8, 1);
    step(); step();
    req_ready = 1'b0; ARESET = 1'b1;
    step();
    check("t6_reset_outputs", 32'({req_valid, req_group, req_sweep, req_last, busy, done,
                                   aborted, err_rsp}), 32'd0);
    ARESET = 1'b0;
    exp_q.delete(); rsp_due.delete(); tb_out = 0;
    rsp_valid = 1'b1;
    step();
    check("t6_err_rsp_set", 32'(err_rsp), 32'd1);
    req_ready = 1'b1; base_x = n_xfer;
    run_start(8, 1);
    check("t6_err_rsp_cleared", 32'(err_rsp), 32'd0);
    repeat (8) step();
    check("t6_count_saturated", 32'(n_xfer - base_x), 32'd4);
    flush_rsps();
    wait_done(200);
    step();
    check("t6_err_rsp_final", 32'(err_rsp), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
